spram_arb: RTL and testbench

SPRAM_ARB -- requirements
Module: spram_arb

---
 rtl/spram_arb.sv | 179 +++++++++++++++++
 tb/tb_spram_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spram_arb.sv
// spram_arb -- two-port arbiter in front of a byte-wide single-port RAM.
//
// Port 0 (CPU) and port 1 (loader/DMA) issue byte or 16-bit word accesses.
// A word is split into two byte cycles, little-endian: low byte at ai,
// high byte at ai+1 (wrapping modulo 2^ASZ). Requesters hold their request
// fields stable until ack, so nothing but the granted port index is stored.
//
// Build option: define ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise port 0 has fixed priority.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req*/we*/wd*      request, write (1) / read (0), word (1) / byte (0)
//   ai*, vi*          byte address (low byte of a word), write data
//   vo*               registered read data per port
//   ack*              one-cycle completion pulse
//   busy              FSM not idle
//   m_ai/m_vi/m_we    memory address / write data / write enable
//   m_vo              memory read data, valid the cycle after its address
module spram_arb #(
  parameter int ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic           we0,
  input  logic           we1,
  input  logic           wd0,
  input  logic           wd1,
  input  logic [ASZ-1:0] ai0,
  input  logic [ASZ-1:0] ai1,
  input  logic [15:0]    vi0,
  input  logic [15:0]    vi1,
  output logic [15:0]    vo0,
  output logic [15:0]    vo1,
  output logic           ack0,
  output logic           ack1,
  output logic           busy,
  output logic [ASZ-1:0] m_ai,
  output logic [7:0]     m_vi,
  output logic           m_we,
  input  logic [7:0]     m_vo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;      // granted port: 0 or 1
  logic [15:0] vo0_q, vo0_d;
  logic [15:0] vo1_q, vo1_d;
`ifdef ARB_RR_EN
  logic        rr_q, rr_d;        // port granted last
`endif

  // Live request fields of the granted port.
  logic           cur_we, cur_wd;
  logic [ASZ-1:0] cur_ai;
  logic [15:0]    cur_vi;
  logic           grant;

  always_comb begin
    cur_we = sel_q ? we1 : we0;
    cur_wd = sel_q ? wd1 : wd0;
    cur_ai = sel_q ? ai1 : ai0;
    cur_vi = sel_q ? vi1 : vi0;
  end

  // Port chosen if the FSM leaves IDLE this cycle.
  always_comb begin
    grant = ~req0;
`ifdef ARB_RR_EN
    if (req0 && req1) grant = ~rr_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vo0_d   = vo0_q;
    vo1_d   = vo1_q;
`ifdef ARB_RR_EN
    rr_d    = rr_q;
`endif
    m_ai    = '0;
    m_vi    = '0;
    m_we    = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_LO;
          sel_d   = grant;
`ifdef ARB_RR_EN
          rr_d    = grant;
`endif
        end
      end

      S_LO: begin
        m_ai    = cur_ai;
        m_vi    = cur_vi[7:0];
        m_we    = cur_we;
        state_d = cur_wd ? S_HI : S_DONE;
      end

      S_HI: begin
        m_ai    = cur_ai + ASZ'(1);   // wraps at the top of memory
        m_vi    = cur_vi[15:8];
        m_we    = cur_we;
        state_d = S_DONE;
        // m_vo now carries the low byte addressed during LO.
        if (!cur_we) begin
          if (sel_q) vo1_d[7:0] = m_vo;
          else       vo0_d[7:0] = m_vo;
        end
      end

      S_DONE: begin
        ack0    = ~sel_q;
        ack1    = sel_q;
        state_d = S_IDLE;
        // m_vo carries the byte addressed in the previous cycle:
        // the whole byte for a byte read, the high byte for a word read.
        if (!cur_we) begin
          if (cur_wd) begin
            if (sel_q) vo1_d[15:8] = m_vo;
            else       vo0_d[15:8] = m_vo;
          end else begin
            if (sel_q) vo1_d = {8'h00, m_vo};
            else       vo0_d = {8'h00, m_vo};
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Reset aborts the in-flight byte cycle too, so a word write cut off
    // in HI never commits its high byte.
    if (rst) begin
      m_ai = '0;
      m_vi = '0;
      m_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      vo0_q   <= '0;
      vo1_q   <= '0;
`ifdef ARB_RR_EN
      rr_q    <= 1'b1;   // port 0 wins the first contention
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vo0_q   <= vo0_d;
      vo1_q   <= vo1_d;
`ifdef ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign vo0  = vo0_q;
  assign vo1  = vo1_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_spram_arb.sv
// Directed testbench for spram_arb with a behavioural byte RAM
// (registered read, one-cycle latency).
module tb_spram_arb;
  localparam int ASZ = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic           we0 = 1'b0, we1 = 1'b0;
  logic           wd0 = 1'b0, wd1 = 1'b0;
  logic [ASZ-1:0] ai0 = '0, ai1 = '0;
  logic [15:0]    vi0 = '0, vi1 = '0;
  logic [15:0]    vo0, vo1;
  logic           ack0, ack1, busy;
  logic [ASZ-1:0] m_ai;
  logic [7:0]     m_vi;
  logic           m_we;
  logic [7:0]     m_vo;

  spram_arb #(.ASZ(ASZ)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .wd0(wd0), .wd1(wd1),
    .ai0(ai0), .ai1(ai1), .vi0(vi0), .vi1(vi1),
    .vo0(vo0), .vo1(vo1), .ack0(ack0), .ack1(ack1), .busy(busy),
    .m_ai(m_ai), .m_vi(m_vi), .m_we(m_we), .m_vo(m_vo)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<ASZ)-1];
  always @(posedge clk) begin
    if (m_we) mem[m_ai] <= m_vi;
    m_vo <= mem[m_ai];
  end

  int n_chk = 0, n_pass = 0, n_ovl = 0;
  always @(negedge clk) if (ack0 && ack1) n_ovl++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 in an IDLE cycle T. lat = cycles from T to ack
  // (-1 on timeout), nwe = cycles with m_we high. Returns at posedge+1 of
  // the IDLE cycle after DONE with req dropped.
  task automatic txn(input bit p, input bit w, input bit wd, input logic [ASZ-1:0] a,
                     input logic [15:0] v, output int lat, output int nwe);
    if (!p) begin we0 = w; wd0 = wd; ai0 = a; vi0 = v; req0 = 1'b1; end
    else    begin we1 = w; wd1 = wd; ai1 = a; vi1 = v; req1 = 1'b1; end
    lat = -1; nwe = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_we) nwe++;
      if (p ? ack1 : ack0) begin lat = k; break; end
    end
    cyc();
    if (!p) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    int lat, nwe, ng;
    logic [3:0] gr, gr_exp;

    // Reset state
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {ack0, ack1}, 0);
    chk("rst_vo", {vo0, vo1}, 0);
    chk("rst_mem_if", {m_we, m_vi, m_ai}, 0);
    cyc();

    // Byte write then read, port 0
    txn(0, 1, 0, 17'h00005, 16'h00A5, lat, nwe);
    chk("bw_lat", lat, 2);
    chk("bw_nwe", nwe, 1);
    chk("bw_mem", mem[17'h00005], 8'hA5);
    txn(0, 0, 0, 17'h00005, 16'h0000, lat, nwe);
    chk("br_lat", lat, 2);
    chk("br_nwe", nwe, 0);
    chk("br_vo0", vo0, 16'h00A5);

    // Word round trip, port 1
    txn(1, 1, 1, 17'h00100, 16'hBEEF, lat, nwe);
    chk("ww_lat", lat, 3);
    chk("ww_nwe", nwe, 2);
    chk("ww_mem_lo", mem[17'h00100], 8'hEF);
    chk("ww_mem_hi", mem[17'h00101], 8'hBE);
    txn(1, 0, 1, 17'h00100, 16'h0000, lat, nwe);
    chk("wr_lat", lat, 3);
    chk("wr_vo1", vo1, 16'hBEEF);

    // Wrap-around at top of memory
    txn(0, 1, 1, 17'h1FFFF, 16'h1234, lat, nwe);
    chk("wrap_mem_lo", mem[17'h1FFFF], 8'h34);
    chk("wrap_mem_hi", mem[17'h00000], 8'h12);
    txn(0, 0, 1, 17'h1FFFF, 16'h0000, lat, nwe);
    chk("wrap_vo0", vo0, 16'h1234);

    // Isolation: port 1 read between port 0 reads; write leaves vo
    txn(1, 0, 0, 17'h00005, 16'h0000, lat, nwe);
    chk("iso_vo1", vo1, 16'h00A5);
    chk("iso_vo0_kept", vo0, 16'h1234);
    txn(0, 0, 0, 17'h00100, 16'h0000, lat, nwe);
    chk("iso_vo0_new", vo0, 16'h00EF);
    chk("iso_vo1_kept", vo1, 16'h00A5);
    txn(0, 1, 0, 17'h00006, 16'h0077, lat, nwe);
    chk("wr_keeps_vo0", vo0, 16'h00EF);

    // Contention: reset first so the pointer favours port 0
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst2_vo", {vo0, vo1}, 0);
    we0 = 0; wd0 = 0; ai0 = 17'h00005;
    we1 = 0; wd1 = 0; ai1 = 17'h00100;
    req0 = 1'b1; req1 = 1'b1;
    ng = 0; gr = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        gr[ng] = ack1;
        ng++;
        if (ng == 4) break;
      end
    end
    cyc();
`ifdef ARB_RR_EN
    gr_exp = 4'b1010;
`else
    gr_exp = 4'b0000;
`endif
    chk("cont_n", ng, 4);
    chk("cont_order", gr, gr_exp);
    // Port 1 is served once port 0 drops its request
    req0 = 1'b0;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack1) begin lat = k; break; end
    end
    cyc(); req1 = 1'b0;
    chk("cont_p1_lat", lat, 2);
    chk("cont_vo0", vo0, 16'h00A5);
    chk("cont_vo1", vo1, 16'h00EF);

    // Reset abort during HI of a word write
    txn(1, 1, 0, 17'h00201, 16'h0099, lat, nwe);
    chk("pre_mem201", mem[17'h00201], 8'h99);
    we0 = 1; wd0 = 1; ai0 = 17'h00200; vi0 = 16'h5566; req0 = 1'b1;
    cyc(); cyc();                  // LO, then HI
    @(negedge clk);
    chk("hi_addr", m_ai, 17'h00201);
    chk("hi_data", {m_we, m_vi}, {1'b1, 8'h55});
    chk("hi_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("hi_rst_we", m_we, 0);
    chk("hi_ack", {ack0, ack1}, 0);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ack", {ack0, ack1}, 0);
    chk("abort_vo", {vo0, vo1}, 0);
    chk("abort_mem200", mem[17'h00200], 8'h66);
    chk("abort_mem201", mem[17'h00201], 8'h99);
    cyc();
    txn(0, 0, 1, 17'h00200, 16'h0000, lat, nwe);
    chk("post_lat", lat, 3);
    chk("post_vo0", vo0, 16'h9966);

    chk("ack_overlap", n_ovl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
